// File: rtl/pending_scoreboard.sv
// pending_scoreboard
//   Hazard scoreboard for a pipelined MIPS core. Each of DEPTH destination slots
//   has a countdown that is loaded with LATENCY when a producer issues and
//   decrements every cycle. The slot is pending while its count is nonzero. A
//   writeback can clear a slot early. An incoming instruction stalls while its
//   source or destination slot is pending.
// Ports
//   clk, rst             clock; synchronous active-high reset
//   issue_valid/dst/src  upstream instruction (holds while stall=1)
//   issue_ready          instruction accepted this cycle
//   stall                instruction blocked by a pending slot
//   wb_valid/wb_dst      early clear of a slot on writeback
//   pending              registered per-slot in-flight bits
//   busy_count           registered popcount of pending
module pending_scoreboard #(
  parameter int unsigned DEPTH   = 6,
  parameter int unsigned LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [3:0]       issue_dst,
  input  logic [3:0]       issue_src,
  output logic             issue_ready,
  output logic             stall,
  input  logic             wb_valid,
  input  logic [3:0]       wb_dst,
  output logic [DEPTH-1:0] pending,
  output logic [3:0]       busy_count
);

  localparam int unsigned CW = $clog2(LATENCY + 1);

  logic [CW-1:0]    cnt     [DEPTH];
  logic [CW-1:0]    cnt_nxt [DEPTH];
  logic [DEPTH-1:0] pend_nxt;
  logic [3:0]       busy_nxt;
  logic             hazard;
  logic             accept;

  // Slot lookups are unrolled compares so indices >= DEPTH simply match nothing.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((issue_src == 4'(i)) && pending[i]) hazard = 1'b1;
      if ((issue_dst == 4'(i)) && pending[i]) hazard = 1'b1;
    end
  end

  assign accept      = issue_valid & ~hazard;
  assign issue_ready = accept;
  assign stall       = issue_valid & hazard;

  // Priority: decrement, then writeback clear, then issue set (new producer wins).
  always_comb begin
    busy_nxt = '0;
    pend_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (cnt[i] != '0) cnt_nxt[i] = cnt[i] - 1'b1;
      if (wb_valid && (wb_dst == 4'(i))) cnt_nxt[i] = '0;
      if (accept && (issue_dst == 4'(i))) cnt_nxt[i] = CW'(LATENCY);
      pend_nxt[i] = (cnt_nxt[i] != '0);
      busy_nxt    = busy_nxt + {3'b000, pend_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) cnt[i] <= '0;
      pending    <= '0;
      busy_count <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) cnt[i] <= cnt_nxt[i];
      pending    <= pend_nxt;
      busy_count <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_pending_scoreboard.sv
// tb_pending_scoreboard
//   Self-checking bench. A behavioural slot model predicts stall/issue_ready each
//   cycle and pushes the expected post-edge pending/busy_count onto a queue that
//   is popped and compared after the clock edge.
module tb_pending_scoreboard;

  localparam int unsigned DEPTH = 6;
  localparam int unsigned LAT   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic [3:0]       issue_dst;
  logic [3:0]       issue_src;
  logic             issue_ready;
  logic             stall;
  logic             wb_valid;
  logic [3:0]       wb_dst;
  logic [DEPTH-1:0] pending;
  logic [3:0]       busy_count;

  pending_scoreboard #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_src(issue_src),
    .issue_ready(issue_ready), .stall(stall),
    .wb_valid(wb_valid), .wb_dst(wb_dst),
    .pending(pending), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: remaining in-flight cycles per slot.
  int mcnt [DEPTH];

  typedef struct packed {
    logic [DEPTH-1:0] pend;
    logic [3:0]       busy;
  } exp_t;
  exp_t expq [$];

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic mpend(input int unsigned idx);
    return (idx < DEPTH) && (mcnt[idx] != 0);
  endfunction

  // One cycle: drive, check combinational outputs, advance model, clock, check registers.
  task automatic cyc(input logic r, input logic v, input int unsigned d, input int unsigned s,
                     input logic wv, input int unsigned wd);
    logic haz, acc;
    exp_t e;
    int   n;
    rst = r; issue_valid = v; issue_dst = 4'(d); issue_src = 4'(s);
    wb_valid = wv; wb_dst = 4'(wd);
    #1;
    haz = mpend(s) | mpend(d);
    acc = v & ~haz;
    check("issue_ready", issue_ready, acc);
    check("stall", stall, v & haz);
    e = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = (mcnt[i] > 0) ? mcnt[i] - 1 : 0;
      if (wv && wd == i) n = 0;
      if (acc && d == i) n = LAT;
      if (r) n = 0;
      mcnt[i] = n;
      if (n != 0) begin
        e.pend[i] = 1'b1;
        e.busy    = e.busy + 4'd1;
      end
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
    e = expq.pop_front();
    check("pending", pending, e.pend);
    check("busy_count", busy_count, e.busy);
  endtask

  task automatic idle(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) cyc(1'b0, 1'b0, 15, 15, 1'b0, 15);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mcnt[i] = 0;
    rst = 1'b1; issue_valid = 1'b0; issue_dst = '0; issue_src = '0;
    wb_valid = 1'b0; wb_dst = '0;
    @(posedge clk);
    #1;

    // 1: reset held with an issue presented; nothing is set afterwards
    cyc(1'b1, 1'b1, 2, 7, 1'b0, 15);
    cyc(1'b1, 1'b1, 2, 7, 1'b0, 15);
    idle(2);

    // 2: single issue lives exactly LAT cycles
    cyc(1'b0, 1'b1, 2, 7, 1'b0, 15);
    idle(4);

    // 3: RAW on slot 4 stalls until the auto-clear
    cyc(1'b0, 1'b1, 4, 15, 1'b0, 15);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 15, 4, 1'b0, 15);
    idle(3);

    // 4: same-cycle writeback does not lift the stall; next cycle accepts
    cyc(1'b0, 1'b1, 1, 15, 1'b0, 15);
    cyc(1'b0, 1'b1, 15, 1, 1'b1, 1);
    cyc(1'b0, 1'b1, 15, 1, 1'b0, 15);
    idle(4);

    // 5: set and clear of the same slot on one edge: set wins
    cyc(1'b0, 1'b1, 3, 15, 1'b0, 15);
    idle(2);
    cyc(1'b0, 1'b1, 3, 15, 1'b1, 3);  // cnt[3]=1 here: dst hazard stalls
    cyc(1'b0, 1'b1, 3, 15, 1'b1, 3);  // slot idle now: accepted, set beats wb
    idle(4);

    // 6: fill slots, out-of-range dst, wb out of range, mid-run reset
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, i, 15, 1'b0, 15);
    cyc(1'b0, 1'b1, 9, 15, 1'b1, 12);
    cyc(1'b0, 1'b1, 0, 15, 1'b0, 15);
    cyc(1'b1, 1'b0, 15, 15, 1'b0, 15);
    idle(2);

    // random traffic, biased towards in-range slots
    for (int k = 0; k < 400; k++)
      cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
          $urandom_range(0, 7), $urandom_range(0, 7),
          ($urandom_range(0, 3) == 0), $urandom_range(0, 7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
